// File: rtl/mem_rr_scheduler_if.sv
// Request/return bus joining the peripheral requesters, the round-robin
// scheduler and the shared single-port frame-buffer RAM.
interface mem_rr_scheduler_if #(
    parameter int ADDRESS_WIDTH = 14,
    parameter int PERIPHERALS   = 2
);
    logic [PERIPHERALS-1:0]               req;
    logic [PERIPHERALS-1:0]               wr;
    logic [ADDRESS_WIDTH*PERIPHERALS-1:0] address;
    logic [8*PERIPHERALS-1:0]             data_in;
    logic [PERIPHERALS-1:0]               gnt;
    logic                                 mem_en;
    logic                                 mem_wr;
    logic [ADDRESS_WIDTH-1:0]             mem_address;
    logic [7:0]                           mem_data_out;
    logic [7:0]                           mem_data_in;
    logic [7:0]                           data_out;
    logic [PERIPHERALS-1:0]               data_out_ready;

    // Scheduler side
    modport slave (
        input  req, wr, address, data_in, mem_data_in,
        output gnt, mem_en, mem_wr, mem_address, mem_data_out, data_out, data_out_ready
    );

    // Requester/RAM side
    modport master (
        output req, wr, address, data_in, mem_data_in,
        input  gnt, mem_en, mem_wr, mem_address, mem_data_out, data_out, data_out_ready
    );
endinterface

// File: rtl/mem_rr_scheduler.sv
// Round-robin owner/burst arbiter for a single-port RAM with a registered
// command port and a one-hot tag pipeline that routes read data back.
module mem_rr_scheduler #(
    parameter int ADDRESS_WIDTH = 14,
    parameter int PERIPHERALS   = 2,
    parameter int READ_LATENCY  = 2,
    parameter int MAX_BURST     = 4
) (
    input  logic               clk,
    input  logic               reset,
    mem_rr_scheduler_if.slave  bus
);
    localparam int IW = (PERIPHERALS > 1) ? $clog2(PERIPHERALS) : 1;
    localparam int CW = $clog2(MAX_BURST + 1);

    typedef enum logic {IDLE, OWNED} state_t;

    state_t                                    state, state_nxt;
    logic [IW-1:0]                             owner, owner_nxt;
    logic [IW-1:0]                             last, last_nxt;
    logic [CW-1:0]                             count, count_nxt;
    logic [PERIPHERALS-1:0]                    gnt, others, rd_tag;
    logic [IW-1:0]                             gidx;
    logic                                      accept, keep;
    int                                        base, idx;
    logic [PERIPHERALS-1:0][ADDRESS_WIDTH-1:0] addr_lane;
    logic [PERIPHERALS-1:0][7:0]               data_lane;
    logic [READ_LATENCY:0][PERIPHERALS-1:0]    tag_pipe;

    for (genvar i = 0; i < PERIPHERALS; i++) begin : g_lane
        assign addr_lane[i] = bus.address[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
        assign data_lane[i] = bus.data_in[i*8 +: 8];
    end

    assign bus.gnt = gnt;

    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        last_nxt  = last;
        count_nxt = count;
        gnt       = '0;
        gidx      = '0;
        accept    = 1'b0;
        base      = 0;
        idx       = 0;
        others    = bus.req & ~(PERIPHERALS'(1) << owner);
        keep      = (state == OWNED) && bus.req[owner] &&
                    ((count < CW'(MAX_BURST)) || (others == '0));

        if (keep) begin
            accept = 1'b1;
            gidx   = owner;
        end else begin
            // Search starts just past the current owner, or past the last
            // served requester when idle, so nobody can be starved.
            base = (state == OWNED) ? int'(owner) : int'(last);
            for (int k = 1; k <= PERIPHERALS; k++) begin
                idx = (base + k) % PERIPHERALS;
                if (!accept && bus.req[IW'(idx)]) begin
                    accept = 1'b1;
                    gidx   = IW'(idx);
                end
            end
        end

        if (reset)
            accept = 1'b0;
        if (accept)
            gnt[gidx] = 1'b1;

        if (accept) begin
            state_nxt = OWNED;
            owner_nxt = gidx;
            if (keep) begin
                count_nxt = (count == CW'(MAX_BURST)) ? CW'(1) : count + CW'(1);
            end else begin
                count_nxt = CW'(1);
                if (state == OWNED)
                    last_nxt = owner;
            end
        end else begin
            state_nxt = IDLE;
            if (state == OWNED)
                last_nxt = owner;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            owner <= '0;
            count <= '0;
            last  <= IW'(PERIPHERALS - 1);
        end else begin
            state <= state_nxt;
            owner <= owner_nxt;
            count <= count_nxt;
            last  <= last_nxt;
        end
    end

    assign rd_tag = (accept && !bus.wr[gidx]) ? gnt : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.mem_en         <= 1'b0;
            bus.mem_wr         <= 1'b0;
            bus.mem_address    <= '0;
            bus.mem_data_out   <= '0;
            bus.data_out       <= '0;
            bus.data_out_ready <= '0;
            tag_pipe           <= '0;
        end else begin
            bus.mem_en <= accept;
            bus.mem_wr <= accept & bus.wr[gidx];
            if (accept) begin
                bus.mem_address  <= addr_lane[gidx];
                bus.mem_data_out <= data_lane[gidx];
            end
            // Tag at the tail lines up with the cycle mem_data_in is valid.
            tag_pipe           <= {tag_pipe[READ_LATENCY-1:0], rd_tag};
            bus.data_out_ready <= tag_pipe[READ_LATENCY];
            if (|tag_pipe[READ_LATENCY])
                bus.data_out <= bus.mem_data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert ($onehot0(gnt));
            assert ((gnt & ~bus.req) == '0);
        end
    end
endmodule

// File: tb/tb_mem_rr_scheduler.sv
// Randomized and directed bench for mem_rr_scheduler against a queue-based
// reference model with a behavioural RAM.
module tb_mem_rr_scheduler;
    localparam int AW = 14;
    localparam int P  = 2;
    localparam int RL = 2;
    localparam int MB = 4;
    localparam int IW = $clog2(P);

    typedef struct packed {
        logic [P-1:0]  gnt;
        logic          mem_en;
        logic          mem_wr;
        logic [AW-1:0] mem_address;
        logic [7:0]    mem_data_out;
        logic [P-1:0]  data_out_ready;
    } ctl_t;

    typedef struct {
        int           due;
        logic [P-1:0] oh;
        logic [7:0]   d;
    } ret_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_rr_scheduler_if #(.ADDRESS_WIDTH(AW), .PERIPHERALS(P)) bus ();

    mem_rr_scheduler #(
        .ADDRESS_WIDTH(AW), .PERIPHERALS(P), .READ_LATENCY(RL), .MAX_BURST(MB)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Behavioural RAM: unwritten cells read a fixed pattern of the address.
    logic [7:0] ram     [1<<AW];
    bit         written [1<<AW];
    logic [7:0] rd_pipe [RL];

    function automatic logic [7:0] init_byte(logic [AW-1:0] a);
        return a[7:0] ^ 8'h79;
    endfunction

    always @(posedge clk) begin
        if (bus.mem_en && bus.mem_wr) begin
            ram[bus.mem_address]     <= bus.mem_data_out;
            written[bus.mem_address] <= 1'b1;
        end
        if (bus.mem_en && !bus.mem_wr)
            rd_pipe[0] <= written[bus.mem_address] ? ram[bus.mem_address] : init_byte(bus.mem_address);
        else
            rd_pipe[0] <= 8'($urandom);
        for (int k = 1; k < RL; k++) rd_pipe[k] <= rd_pipe[k-1];
    end
    assign bus.mem_data_in = rd_pipe[RL-1];

    int checks, errors, cyc;
    logic                 rst_v;
    logic [P-1:0]         req_v, wr_v;
    logic [P-1:0][AW-1:0] addr_v;
    logic [P-1:0][7:0]    din_v;

    // Reference model state
    int            own, run, last;
    logic          m_en, m_wr;
    logic [AW-1:0] m_addr;
    logic [7:0]    m_data;
    logic [7:0]    shadow [int];
    ret_t          rq [$];
    ctl_t          got, want;
    logic [7:0]    got_dout, want_dout;

    function automatic logic [7:0] sh_rd(logic [AW-1:0] a);
        return shadow.exists(int'(a)) ? shadow[int'(a)] : init_byte(a);
    endfunction

    function automatic int pick();
        bit others = 0;
        int start;
        for (int i = 0; i < P; i++) if (i != own && req_v[IW'(i)]) others = 1;
        if (own >= 0 && req_v[IW'(own)] && (run < MB || !others)) return own;
        start = (own >= 0) ? own : last;
        for (int k = 1; k <= P; k++) if (req_v[IW'((start + k) % P)]) return (start + k) % P;
        return -1;
    endfunction

    // One clock: apply inputs, capture outputs and model predictions, advance.
    task automatic tick();
        int g;
        logic [IW-1:0] gi;
        reset = rst_v; bus.req = req_v; bus.wr = wr_v; bus.address = addr_v; bus.data_in = din_v;
        #1;
        g  = rst_v ? -1 : pick();
        gi = IW'(g);
        want.gnt          = (g < 0) ? '0 : P'(1) << g;
        want.mem_en       = m_en;
        want.mem_wr       = m_wr;
        want.mem_address  = m_addr;
        want.mem_data_out = m_data;
        want.data_out_ready = '0;
        if (rq.size() > 0 && rq[0].due == cyc) begin
            want.data_out_ready = rq[0].oh;
            want_dout = rq[0].d;
            void'(rq.pop_front());
        end
        got.gnt = bus.gnt; got.mem_en = bus.mem_en; got.mem_wr = bus.mem_wr;
        got.mem_address = bus.mem_address; got.mem_data_out = bus.mem_data_out;
        got.data_out_ready = bus.data_out_ready;
        got_dout = bus.data_out;
        if (rst_v) begin
            m_en = 0; m_wr = 0; m_addr = '0; m_data = '0;
            rq.delete(); own = -1; run = 0; last = P - 1;
        end else begin
            m_en = (g >= 0); m_wr = 0;
            if (g >= 0) begin
                m_wr = wr_v[gi]; m_addr = addr_v[gi]; m_data = din_v[gi];
                if (wr_v[gi]) shadow[int'(addr_v[gi])] = din_v[gi];
                else rq.push_back('{due: cyc + 2 + RL, oh: P'(1) << g, d: sh_rd(addr_v[gi])});
                if (g == own) run = (run == MB) ? 1 : run + 1;
                else begin
                    if (own >= 0) last = own;
                    own = g; run = 1;
                end
            end else begin
                if (own >= 0) last = own;
                own = -1;
            end
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic test_reset();
        rst_v = 1;
        for (int k = 0; k < 3; k++) begin
            req_v = P'($urandom); wr_v = P'($urandom);
            tick();
            checks++;
            if (got.gnt !== '0) begin errors++; $display("FAIL reset_gnt got=%b want=0", got.gnt); end
        end
        rst_v = 0; req_v = '0;
        tick();
        checks++;
        if (got !== '0) begin errors++; $display("FAIL reset_state got=%h want=0", got); end
        checks++;
        if (got_dout !== 8'h00) begin errors++; $display("FAIL reset_dout got=%h want=00", got_dout); end
    endtask

    task automatic test_single_read();
        for (int k = 0; k < 7; k++) begin
            req_v = (k == 0) ? 2'b01 : 2'b00; wr_v = '0; addr_v[0] = 14'h0123;
            tick();
            checks++;
            if (got !== want) begin errors++; $display("FAIL single_read cyc=%0d got=%h want=%h", cyc, got, want); end
            if (k == 0) begin
                checks++;
                if (got.gnt !== 2'b01) begin errors++; $display("FAIL single_read_gnt got=%b want=01", got.gnt); end
            end
            if (k == 1) begin
                checks++;
                if ({got.mem_en, got.mem_wr, got.mem_address} !== {1'b1, 1'b0, 14'h0123}) begin
                    errors++; $display("FAIL single_read_cmd got=%b/%b/%h want=1/0/0123", got.mem_en, got.mem_wr, got.mem_address);
                end
            end
            if (k == 4) begin
                checks++;
                if ({got_dout, got.data_out_ready} !== {8'h5A, 2'b01}) begin
                    errors++; $display("FAIL single_read_ret got=%h/%b want=5a/01", got_dout, got.data_out_ready);
                end
            end
        end
    endtask

    task automatic test_write();
        for (int k = 0; k < 12; k++) begin
            req_v = (k == 0) ? 2'b10 : (k == 6) ? 2'b01 : 2'b00;
            wr_v = 2'b10; addr_v[1] = 14'h3FFF; din_v[1] = 8'hA5; addr_v[0] = 14'h3FFF;
            tick();
            checks++;
            if (got !== want) begin errors++; $display("FAIL write cyc=%0d got=%h want=%h", cyc, got, want); end
            if (want.data_out_ready != '0) begin
                checks++;
                if (got_dout !== want_dout) begin errors++; $display("FAIL write_readback got=%h want=%h", got_dout, want_dout); end
            end
            if (k == 1) begin
                checks++;
                if ({got.mem_en, got.mem_wr, got.mem_address, got.mem_data_out} !== {1'b1, 1'b1, 14'h3FFF, 8'hA5}) begin
                    errors++; $display("FAIL write_cmd got=%b/%b/%h/%h want=1/1/3fff/a5", got.mem_en, got.mem_wr, got.mem_address, got.mem_data_out);
                end
            end
            if (k >= 1 && k <= 5) begin
                checks++;
                if (got.data_out_ready !== 2'b00) begin errors++; $display("FAIL write_no_ret got=%b want=00", got.data_out_ready); end
            end
        end
    endtask

    task automatic test_contention();
        rst_v = 1; req_v = '0; tick(); rst_v = 0;
        for (int k = 0; k < 24; k++) begin
            req_v = (k < 16) ? 2'b11 : 2'b00; wr_v = '0;
            for (int i = 0; i < P; i++) addr_v[IW'(i)] = AW'($urandom);
            tick();
            checks++;
            if (got !== want) begin errors++; $display("FAIL contention cyc=%0d got=%h want=%h", cyc, got, want); end
            if (want.data_out_ready != '0) begin
                checks++;
                if (got_dout !== want_dout) begin errors++; $display("FAIL contention_data got=%h want=%h", got_dout, want_dout); end
            end
            if (k < 16) begin
                checks++;
                if (got.gnt !== (((k / 4) % 2) ? 2'b10 : 2'b01)) begin
                    errors++; $display("FAIL contention_order k=%0d got=%b want=%b", k, got.gnt, ((k / 4) % 2) ? 2'b10 : 2'b01);
                end
            end
        end
    endtask

    task automatic test_sole_requester();
        int n = 0;
        for (int k = 0; k < 16; k++) begin
            req_v = (k < 10) ? 2'b10 : 2'b00; wr_v = '0; addr_v[1] = AW'(k);
            tick();
            checks++;
            if (got !== want) begin errors++; $display("FAIL sole cyc=%0d got=%h want=%h", cyc, got, want); end
            if (k < 10) begin
                checks++;
                if (got.gnt !== 2'b10) begin errors++; $display("FAIL sole_gnt k=%0d got=%b want=10", k, got.gnt); end
            end
            if (k >= 1 && k <= 10 && got.mem_en === 1'b1) n++;
        end
        checks++;
        if (n != 10) begin errors++; $display("FAIL sole_pulses got=%0d want=10", n); end
    endtask

    task automatic test_owner_drop();
        rst_v = 1; req_v = '0; tick(); rst_v = 0;
        for (int k = 0; k < 10; k++) begin
            req_v = (k < 2) ? 2'b11 : (k < 4) ? 2'b10 : 2'b00; wr_v = '0;
            tick();
            checks++;
            if (got !== want) begin errors++; $display("FAIL owner_drop cyc=%0d got=%h want=%h", cyc, got, want); end
            if (k == 2) begin
                checks++;
                if (got.gnt !== 2'b10) begin errors++; $display("FAIL owner_drop_gnt got=%b want=10", got.gnt); end
            end
            if (k >= 1 && k <= 4) begin
                checks++;
                if (got.mem_en !== 1'b1) begin errors++; $display("FAIL owner_drop_bubble k=%0d got=%b want=1", k, got.mem_en); end
            end
        end
    endtask

    task automatic test_reset_mid();
        ctl_t post;
        post = '0; post.gnt = 2'b01;
        for (int k = 0; k < 12; k++) begin
            rst_v = (k == 3);
            req_v = (k < 3) ? 2'b01 : (k == 4) ? 2'b11 : 2'b00; wr_v = '0;
            addr_v[0] = AW'($urandom);
            tick();
            checks++;
            if (got !== want) begin errors++; $display("FAIL reset_mid cyc=%0d got=%h want=%h", cyc, got, want); end
            if (k == 4) begin
                checks++;
                if (got !== post) begin errors++; $display("FAIL reset_mid_post got=%h want=%h", got, post); end
            end
            if (k >= 4 && k <= 7) begin
                checks++;
                if (got.data_out_ready !== 2'b00) begin errors++; $display("FAIL reset_mid_flush k=%0d got=%b want=00", k, got.data_out_ready); end
            end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 420; k++) begin
            rst_v = ($urandom_range(0, 63) == 0);
            req_v = (k < 400) ? P'($urandom) : '0;
            wr_v  = P'($urandom);
            for (int i = 0; i < P; i++) begin
                addr_v[IW'(i)] = AW'($urandom_range(0, 15));
                din_v[IW'(i)]  = 8'($urandom);
            end
            tick();
            checks++;
            if (got !== want) begin errors++; $display("FAIL random cyc=%0d got=%h want=%h", cyc, got, want); end
            if (want.data_out_ready != '0) begin
                checks++;
                if (got_dout !== want_dout) begin errors++; $display("FAIL random_data cyc=%0d got=%h want=%h", cyc, got_dout, want_dout); end
            end
        end
    endtask

    initial begin
        checks = 0; errors = 0; cyc = 0;
        own = -1; run = 0; last = P - 1;
        m_en = 0; m_wr = 0; m_addr = '0; m_data = '0; want_dout = '0;
        rst_v = 1; req_v = '0; wr_v = '0; addr_v = '0; din_v = '0;
        test_reset();
        test_single_read();
        test_write();
        test_contention();
        test_sole_requester();
        test_owner_drop();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
